// File: rtl/fifo_rd_unpack_pkg.sv
// Shared definitions for the FIFO read-side unpacker: prefetch buffer states
// and a width helper for the beat counter.
package fifo_rd_unpack_pkg;

  // Occupancy of the two-word prefetch buffer (cur, nxt).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never less than one so a RATIO of 1 still
  // gets a real (constant-zero) counter register.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_rd_unpack.sv
// Drains a show-ahead FIFO read port and emits each W-bit word as RATIO
// narrower beats (LSB slice first) on a valid/ready stream.
module fifo_rd_unpack
  import fifo_rd_unpack_pkg::*;
#(
  parameter int W     = 8,
  parameter int RATIO = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fifo_empty,
  output logic            fifo_rd_en,
  input  logic [W-1:0]    fifo_rd_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [W/RATIO-1:0] m_data,
  output logic            m_last,
  output logic            busy
);

  localparam int OW = W / RATIO;
  localparam int BW = clog2_min1(RATIO);
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  if ((RATIO < 1) || (RATIO > 16) || ((W % RATIO) != 0)) begin : g_bad_params
    $error("fifo_rd_unpack: W must be a multiple of RATIO and RATIO in 1..16");
  end

  state_t        state;
  logic [BW-1:0] beat;
  logic [W-1:0]  cur;
  logic [W-1:0]  nxt;
  logic          rst_done;

  logic load;
  logic xfer;
  logic retire;

  // Popping depends only on registered state, never on m_ready, so the sink's
  // ready has no combinational path back into the FIFO.
  assign fifo_rd_en = rst_done && !fifo_empty && (state != ST_TWO);
  assign load       = fifo_rd_en;

  assign m_valid = (state != ST_EMPTY);
  assign busy    = (state != ST_EMPTY);
  assign xfer    = m_valid && m_ready;
  assign retire  = xfer && (beat == LAST_BEAT);

  assign m_data = cur[int'(beat)*OW +: OW];
  assign m_last = m_valid && (beat == LAST_BEAT);

  // NOTE: state lives in always_ff with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // The data registers are reset too, which makes m_data read zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_EMPTY;
      beat     <= '0;
      cur      <= '0;
      nxt      <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;

      if (xfer) begin
        beat <= retire ? '0 : beat + 1'b1;
      end

      case (state)
        ST_EMPTY: begin
          if (load) begin
            state <= ST_ONE;
            cur   <= fifo_rd_data;
          end
        end
        ST_ONE: begin
          if (load && !retire) begin
            state <= ST_TWO;
            nxt   <= fifo_rd_data;
          end else if (load && retire) begin
            cur <= fifo_rd_data;
          end else if (retire) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // No pop is possible here, so the only move is promoting nxt.
          if (retire) begin
            state <= ST_ONE;
            cur   <= nxt;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_rd_en && fifo_empty));

  a_stream_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

endmodule
